data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for processor data load/store traffic: accepts one request at a time over a valid/ready handshake, inserts a programmable wait-state delay, performs the word access on an internal RAM, then returns a response over a second valid/ready handshake.
- Replaces the zero-latency data memory when the processor core is moved to a stall-capable bus, and lets verification model slow memory.

Parameters:
DEPTH, 256, number of 32-bit words in the backing RAM (power of two, 4..65536)
LATENCY, 2, wait-state cycles between request acceptance and memory access (0..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_wstrb  input  4  byte enables for stores (bit i enables bits 8i+7..8i); ignored on loads
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts the response
resp_rdata  output  32  load data; 0 for stores and for errors
resp_err  output  1  request rejected (misaligned or out of range)

Behaviour:
- Reset (rst=0 at a rising edge): state=IDLE, count=0, resp_valid=0, resp_rdata=0, resp_err=0. req_ready=0 while rst=0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1 (when rst=1).
  - On req_valid & req_ready: latch write, addr, wdata, wstrb; load count=LATENCY; go to WAIT.
  - Without req_valid, stay in IDLE.
- WAIT:
  - req_ready=0.
  - count>0: decrement count.
  - count==0: on this edge perform the access and go to RESP.
- Access rules (word index = addr[31:2]):
  - Error if addr[1:0]!=0 or index>=DEPTH. Then no RAM change, resp_err=1, resp_rdata=0.
  - Load: resp_rdata=RAM[index], resp_err=0.
  - Store: for each i with wstrb[i]=1, RAM[index] byte i = wdata byte i; resp_rdata=0, resp_err=0. wstrb=0 is a legal no-op store, still acknowledged.
- RESP:
  - resp_valid=1 and req_ready=0. resp_rdata and resp_err are held stable.
  - On resp_ready=1: clear resp_valid, resp_rdata and resp_err to 0; go to IDLE.
  - No new request is accepted in the same cycle as the response handshake. Back-to-back throughput is one request per LATENCY+3 cycles.
- Latency: request accepted at edge k; resp_valid is first high after edge k+1+LATENCY. With LATENCY=0, resp_valid is high after edge k+1.
- req_* inputs are ignored outside the acceptance cycle. Changes to them during WAIT or RESP have no effect.
- Reset mid-operation: any in-flight request is dropped and state returns to IDLE.
  - A store in WAIT that has not reached its access edge is never committed.
  - A store already in RESP stays committed.
- Outputs are registered, except req_ready, which is a decode of state and rst.

Test Plan:
1. Reset, then LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, accepted at edge k -> resp_valid high after edge k+3, rdata 0, err 0. Then load 0x10 -> rdata 0xDEADBEEF, same latency.
2. Byte strobes: RAM[5]=0x11223344, store addr 0x14, wdata 0xAABBCCDD, wstrb 0x5 -> subsequent load at 0x14 returns 0x11BB33DD.
3. Errors: load at 0x13 -> resp_err=1, rdata 0. Store at byte address 4*DEPTH with wstrb 0xF -> resp_err=1, and a load of word 0 is unchanged.
4. Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata and err stay stable and req_ready stays 0. Raise resp_ready -> resp_valid=0 next cycle and req_ready=1.
5. Reset mid-WAIT: store 0x55 to addr 0x8, assert rst=0 one cycle after acceptance -> resp_valid never rises, and a later load of 0x8 returns the old value. Also check LATENCY=0 gives resp_valid one edge after acceptance.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response handshake bundle between a data-side master and the memory responder.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    modport master (output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
                    input  req_ready, resp_valid, resp_rdata, resp_err);
    modport slave  (input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
                    output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding word RAM responder with programmable wait states.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input logic clk,
    input logic rst,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      r_state, w_next;
    logic [3:0]  r_count;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_valid;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];
    logic        w_ready, w_accept, w_access, w_err;
    logic [AW-1:0] w_idx;
    assign w_idx = r_addr[AW+1:2];
    assign w_err = (|r_addr[1:0]) | (|r_addr[31:AW+2]);
    always_ff @(posedge clk)
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    always_comb begin
        w_ready  = rst && r_state == IDLE;
        w_accept = w_ready && bus.req_valid;
        w_access = r_state == WAIT && r_count == 4'd0;
        w_next   = r_state == IDLE ? (bus.req_valid ? WAIT : IDLE) :
                   r_state == WAIT ? (r_count == 4'd0 ? RESP : WAIT) :
                   (bus.resp_ready ? IDLE : RESP);
    end
    always_ff @(posedge clk)
        if (!rst) begin
            r_count <= 4'd0;
            r_valid <= 1'b0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= bus.req_write;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_wstrb <= bus.req_wstrb;
                r_count <= 4'(LATENCY);
            end else if (r_state == WAIT && r_count != 4'd0) r_count <= r_count - 4'd1;
            if (w_access) begin
                r_valid <= 1'b1;
                r_rdata <= (r_write || w_err) ? 32'd0 : r_mem[w_idx];
                r_err   <= w_err;
            end else if (r_state == RESP && bus.resp_ready) begin
                r_valid <= 1'b0;
                r_rdata <= 32'd0;
                r_err   <= 1'b0;
            end
        end
    // Gated by rst so a store caught by reset on its access edge is never committed
    always_ff @(posedge clk)
        if (rst && w_access && r_write && !w_err)
            for (int i = 0; i < 4; i++)
                if (r_wstrb[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = r_valid;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of latency, strobes, errors, backpressure and reset for the responder.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    data_mem_responder_if mi ();
    data_mem_responder_if mz ();
    data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (.clk(clk), .rst(rst), .bus(mi.slave));
    data_mem_responder #(.DEPTH(256), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(mz.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int hold, output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        mi.req_valid = 1'b1;
        mi.req_write = w;
        mi.req_addr  = a;
        mi.req_wdata = d;
        mi.req_wstrb = s;
        chk("req_ready_idle", 32'(mi.req_ready), 32'd1);
        @(posedge clk);
        #1;
        mi.req_valid = 1'b0;
        mi.req_addr  = 32'hFFFF_FFFF;
        mi.req_wdata = 32'h0BAD_0BAD;
        mi.req_write = ~w;
        lat = 0;
        @(negedge clk);
        while (!mi.resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = mi.resp_rdata;
        er = mi.resp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(mi.resp_valid), 32'd1);
            chk("hold_rdata", mi.resp_rdata, rd);
            chk("hold_err", 32'(mi.resp_err), 32'(er));
            chk("hold_ready", 32'(mi.req_ready), 32'd0);
        end
        mi.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        mi.resp_ready = 1'b0;
        @(negedge clk);
        chk("post_valid", 32'(mi.resp_valid), 32'd0);
        chk("post_rdata", mi.resp_rdata, 32'd0);
        chk("post_ready", 32'(mi.req_ready), 32'd1);
    endtask
    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        mi.req_valid = 0; mi.req_write = 0; mi.req_addr = 0; mi.req_wdata = 0; mi.req_wstrb = 0; mi.resp_ready = 0;
        mz.req_valid = 0; mz.req_write = 0; mz.req_addr = 0; mz.req_wdata = 0; mz.req_wstrb = 0; mz.resp_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(mi.req_ready), 32'd0);
        chk("rst_valid", 32'(mi.resp_valid), 32'd0);
        chk("rst_rdata", mi.resp_rdata, 32'd0);
        chk("rst_err", 32'(mi.resp_err), 32'd0);
        rst = 1'b1;
        txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
        chk("st_lat", 32'(lat), 32'd3);
        chk("st_rdata", rd, 32'd0);
        chk("st_err", 32'(er), 32'd0);
        txn(0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        chk("ld_lat", 32'(lat), 32'd3);
        chk("ld_rdata", rd, 32'hDEADBEEF);
        chk("ld_err", 32'(er), 32'd0);
        txn(1, 32'h14, 32'h11223344, 4'hF, 0, rd, er, lat);
        txn(1, 32'h14, 32'hAABBCCDD, 4'h5, 0, rd, er, lat);
        chk("strb_err", 32'(er), 32'd0);
        txn(0, 32'h14, 32'h0, 4'h0, 0, rd, er, lat);
        chk("strb_rdata", rd, 32'h11BB33DD);
        txn(1, 32'h14, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat);
        chk("nostrb_err", 32'(er), 32'd0);
        chk("nostrb_lat", 32'(lat), 32'd3);
        txn(0, 32'h14, 32'h0, 4'h0, 0, rd, er, lat);
        chk("nostrb_rdata", rd, 32'h11BB33DD);
        txn(0, 32'h13, 32'h0, 4'h0, 0, rd, er, lat);
        chk("mis_err", 32'(er), 32'd1);
        chk("mis_rdata", rd, 32'd0);
        txn(1, 32'h0, 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
        txn(1, 32'h400, 32'h12345678, 4'hF, 0, rd, er, lat);
        chk("oor_err", 32'(er), 32'd1);
        chk("oor_rdata", rd, 32'd0);
        txn(0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
        chk("oor_word0", rd, 32'hCAFEF00D);
        txn(0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
        chk("bp_rdata", rd, 32'hDEADBEEF);
        chk("bp_err", 32'(er), 32'd0);
        txn(1, 32'h8, 32'h12345678, 4'hF, 0, rd, er, lat);
        @(negedge clk);
        mi.req_valid = 1'b1; mi.req_write = 1'b1; mi.req_addr = 32'h8; mi.req_wdata = 32'h55; mi.req_wstrb = 4'hF;
        @(posedge clk);
        #1;
        mi.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", 32'(mi.req_ready), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mid_rst_valid", 32'(mi.resp_valid), 32'd0);
        end
        txn(0, 32'h8, 32'h0, 4'h0, 0, rd, er, lat);
        chk("mid_rst_old", rd, 32'h12345678);
        @(negedge clk);
        mz.req_valid = 1'b1; mz.req_write = 1'b1; mz.req_addr = 32'h4; mz.req_wdata = 32'h0A0B0C0D; mz.req_wstrb = 4'hF;
        chk("z_ready", 32'(mz.req_ready), 32'd1);
        @(posedge clk);
        #1;
        mz.req_valid = 1'b0;
        @(negedge clk);
        chk("z_valid_early", 32'(mz.resp_valid), 32'd0);
        @(negedge clk);
        chk("z_valid", 32'(mz.resp_valid), 32'd1);
        chk("z_err", 32'(mz.resp_err), 32'd0);
        mz.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        mz.resp_ready = 1'b0;
        @(negedge clk);
        chk("z_post_valid", 32'(mz.resp_valid), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
